// File: rtl/sym_fifo_pkg.sv
// Shared definitions for the RS(16,8) decoder symbol buffering:
// symbol width, default depth and a ceiling-log2 helper for sizing counters.
package sym_fifo_pkg;

    localparam int SYM_W         = 8;
    localparam int DEPTH_DEFAULT = 16;

    // Number of bits needed to hold the values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sym_fifo_ram.sv
// DEPTH x WIDTH symbol storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module sym_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sym_fifo.sv
// Parametrised symbol FIFO between the syndrome/Chien stages and error correction.
// Arbitrary depth, sticky overflow/underflow, watermarks, flush and optional FWFT output.
module sym_fifo
    import sym_fifo_pkg::*;
#(
    parameter  int WIDTH     = SYM_W,
    parameter  int DEPTH     = DEPTH_DEFAULT,
    parameter  int FWFT      = 0,
    parameter  int AF_MARGIN = 2,
    parameter  int AE_MARGIN = 2,
    localparam int PTR_W     = clog2(DEPTH),
    localparam int LVL_W     = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             clr_err,
    input  logic             wr,
    input  logic [WIDTH-1:0] datain,
    input  logic             rd,
    output logic [WIDTH-1:0] dataout,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [LVL_W-1:0] level,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AF_LVL   = LVL_W'(DEPTH - AF_MARGIN);
    localparam logic [LVL_W-1:0] AE_LVL   = LVL_W'(AE_MARGIN);

    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] dataout_q, dataout_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             rd_ok;
    logic             wr_ok;
    logic             ram_we;
    logic [WIDTH-1:0] ram_rdata;

    sym_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wptr_q),
        .wdata (datain),
        .raddr (rptr_q),
        .rdata (ram_rdata)
    );

    assign empty        = (level_q == '0);
    assign full         = (level_q == LVL_FULL);
    assign almost_empty = (level_q <= AE_LVL);
    assign almost_full  = (level_q >= AF_LVL);
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_ok  = rd & ~empty;
    assign wr_ok  = wr & (~full | rd_ok);
    assign ram_we = wr_ok & ~flush;

    always_comb begin
        rptr_d      = rptr_q;
        wptr_d      = wptr_q;
        level_d     = level_q;
        dataout_d   = dataout_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            level_d = '0;
        end else begin
            if (wr_ok) begin
                wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
            end
            if (rd_ok) begin
                rptr_d    = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
                dataout_d = ram_rdata;
            end
            level_d = level_q + LVL_W'(wr_ok) - LVL_W'(rd_ok);
            // A new error in the clearing cycle keeps the flag set.
            overflow_d  = (wr & full & ~rd_ok) | (overflow_q & ~clr_err);
            underflow_d = (rd & empty) | (underflow_q & ~clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q      <= '0;
            wptr_q      <= '0;
            level_q     <= '0;
            dataout_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            level_q     <= level_d;
            dataout_q   <= dataout_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        dataout = dataout_q;
        if (FWFT != 0) begin
            dataout = empty ? '0 : ram_rdata;
        end
    end

endmodule
